// File: rtl/lsu_seq_ctrl.sv
// Context sequencer: replays a table of LSU bursts, one idle gap between bursts and a Finish cycle at run end.
// Outputs are registered (start -> first beat next cycle); stall_in suspends beat issue and re-bases the address on resume.
module lsu_seq_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int IDX_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cfg_we_in,
  input  logic [IDX_W-1:0]  cfg_idx_in,
  input  logic [1:0]        cfg_op_in,
  input  logic [ADDR_W-1:0] cfg_base_in,
  input  logic [LEN_W-1:0]  cfg_len_in,
  input  logic              start_in,
  input  logic [IDX_W-1:0]  last_idx_in,
  input  logic              stall_in,
  input  logic              abort_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [IDX_W-1:0]  ctx_idx_out,
  output logic              LSU_En_out,
  output logic [ADDR_W+1:0] LSU_CFG_out,
  output logic              LSU_Finish_out
);

  localparam int DEPTH = 1 << IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

  logic [1:0]        op_mem   [DEPTH];
  logic [ADDR_W-1:0] base_mem [DEPTH];
  logic [LEN_W-1:0]  len_mem  [DEPTH];

  logic [1:0]        state_q,   state_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic [LEN_W-1:0]  cnt_q,     cnt_d;
  logic [ADDR_W-1:0] seg_q,     seg_d;
  logic [IDX_W-1:0]  last_q,    last_d;
  logic              stalled_q, stalled_d;
  logic              en_q,      en_d;
  logic [ADDR_W+1:0] cfg_q,     cfg_d;
  logic              fin_q;
  logic              busy_q;
  logic [IDX_W-1:0]  ctx_q;

  logic              beat_req;
  logic [ADDR_W-1:0] rebase;

  // Table has no reset: contents survive RST and are only writable while idle.
  always_ff @(posedge CLK) begin
    if (!RST && state_q == S_IDLE && cfg_we_in) begin
      op_mem[cfg_idx_in]   <= cfg_op_in;
      base_mem[cfg_idx_in] <= cfg_base_in;
      len_mem[cfg_idx_in]  <= cfg_len_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    seg_d     = seg_q;
    last_d    = last_q;
    stalled_d = stalled_q;
    en_d      = 1'b0;
    cfg_d     = cfg_q;
    beat_req  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_in && !cfg_we_in) begin
          idx_d     = IDX_ZERO;
          cnt_d     = '0;
          seg_d     = base_mem[IDX_ZERO];
          last_d    = last_idx_in;
          stalled_d = 1'b0;
          if (len_mem[IDX_ZERO] == '0) begin
            state_d = S_GAP;
          end else begin
            state_d  = S_RUN;
            beat_req = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort_in) begin
          state_d = S_FIN;
        end else if (cnt_q == len_mem[idx_q]) begin
          state_d = (idx_q == last_q) ? S_FIN : S_GAP;
        end else begin
          beat_req = 1'b1;
        end
      end
      S_GAP: begin
        if (abort_in || idx_q == last_q) begin
          state_d = S_FIN;
        end else begin
          idx_d     = idx_q + IDX_ONE;
          cnt_d     = '0;
          seg_d     = base_mem[idx_d];
          stalled_d = 1'b0;
          if (len_mem[idx_d] == '0) begin
            state_d = S_GAP;
          end else begin
            state_d  = S_RUN;
            beat_req = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The LSU restarts its offset whenever En drops, so after a stall the base must skip the beats already done.
    rebase = base_mem[idx_d] + ADDR_W'(cnt_d);
    if (beat_req) begin
      if (stall_in) begin
        stalled_d = 1'b1;
      end else begin
        if (stalled_d) begin
          seg_d = rebase;
        end
        en_d      = 1'b1;
        cfg_d     = {op_mem[idx_d], seg_d};
        cnt_d     = cnt_d + CNT_ONE;
        stalled_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      seg_q     <= '0;
      last_q    <= '0;
      stalled_q <= 1'b0;
      en_q      <= 1'b0;
      cfg_q     <= '0;
      fin_q     <= 1'b0;
      busy_q    <= 1'b0;
      ctx_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      seg_q     <= seg_d;
      last_q    <= last_d;
      stalled_q <= stalled_d;
      en_q      <= en_d;
      cfg_q     <= cfg_d;
      fin_q     <= (state_d == S_FIN);
      busy_q    <= (state_d != S_IDLE);
      ctx_q     <= idx_d;
    end
  end

  assign busy_out       = busy_q;
  assign done_out       = fin_q;
  assign ctx_idx_out    = ctx_q;
  assign LSU_En_out     = en_q;
  assign LSU_CFG_out    = cfg_q;
  assign LSU_Finish_out = fin_q;

endmodule

// File: tb/tb_lsu_seq_ctrl.sv
// Directed bench for lsu_seq_ctrl: hand-computed En/CFG/Finish/ctx per cycle.
module tb_lsu_seq_ctrl;

  localparam logic [1:0] OP_LDW = 2'b01;
  localparam logic [1:0] OP_STW = 2'b10;

  logic        CLK;
  logic        RST;
  logic        cfg_we_in;
  logic [3:0]  cfg_idx_in;
  logic [1:0]  cfg_op_in;
  logic [9:0]  cfg_base_in;
  logic [7:0]  cfg_len_in;
  logic        start_in;
  logic [3:0]  last_idx_in;
  logic        stall_in;
  logic        abort_in;
  logic        busy_out;
  logic        done_out;
  logic [3:0]  ctx_idx_out;
  logic        LSU_En_out;
  logic [11:0] LSU_CFG_out;
  logic        LSU_Finish_out;

  int checks;
  int failures;

  lsu_seq_ctrl dut (
    .CLK            (CLK),
    .RST            (RST),
    .cfg_we_in      (cfg_we_in),
    .cfg_idx_in     (cfg_idx_in),
    .cfg_op_in      (cfg_op_in),
    .cfg_base_in    (cfg_base_in),
    .cfg_len_in     (cfg_len_in),
    .start_in       (start_in),
    .last_idx_in    (last_idx_in),
    .stall_in       (stall_in),
    .abort_in       (abort_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .ctx_idx_out    (ctx_idx_out),
    .LSU_En_out     (LSU_En_out),
    .LSU_CFG_out    (LSU_CFG_out),
    .LSU_Finish_out (LSU_Finish_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle's outputs, then advance one clock.
  task automatic cyc(input string tag, input logic en, input logic [11:0] cfg,
                     input logic fin, input logic [3:0] ctx);
    chk({tag, ".en"},   32'(LSU_En_out),     32'(en));
    chk({tag, ".cfg"},  32'(LSU_CFG_out),    32'(cfg));
    chk({tag, ".fin"},  32'(LSU_Finish_out), 32'(fin));
    chk({tag, ".done"}, 32'(done_out),       32'(fin));
    chk({tag, ".ctx"},  32'(ctx_idx_out),    32'(ctx));
    tick();
  endtask

  task automatic wr(input logic [3:0] idx, input logic [1:0] op,
                    input logic [9:0] base, input logic [7:0] len);
    cfg_we_in   = 1'b1;
    cfg_idx_in  = idx;
    cfg_op_in   = op;
    cfg_base_in = base;
    cfg_len_in  = len;
    tick();
    cfg_we_in   = 1'b0;
  endtask

  task automatic go(input logic [3:0] last);
    last_idx_in = last;
    start_in    = 1'b1;
    tick();
    start_in    = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".en"},   32'(LSU_En_out),     0);
    chk({tag, ".cfg"},  32'(LSU_CFG_out),    0);
    chk({tag, ".fin"},  32'(LSU_Finish_out), 0);
    chk({tag, ".done"}, 32'(done_out),       0);
    chk({tag, ".busy"}, 32'(busy_out),       0);
    chk({tag, ".ctx"},  32'(ctx_idx_out),    0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    RST         = 1'b1;
    cfg_we_in   = 1'b0;
    cfg_idx_in  = '0;
    cfg_op_in   = '0;
    cfg_base_in = '0;
    cfg_len_in  = '0;
    start_in    = 1'b0;
    last_idx_in = '0;
    stall_in    = 1'b0;
    abort_in    = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    RST = 1'b0;

    // Single entry: 4 beats of 0x410 then one Finish cycle.
    wr(4'd0, OP_LDW, 10'h010, 8'd4);
    go(4'd0);
    chk("t1.busy", 32'(busy_out), 1);
    for (int i = 0; i < 4; i++) cyc("t1.beat", 1'b1, 12'h410, 1'b0, 4'd0);
    cyc("t1.fin", 1'b0, 12'h410, 1'b1, 4'd0);
    chk("t1.busy_after", 32'(busy_out), 0);

    // Two entries with one gap cycle between them.
    wr(4'd0, OP_LDW, 10'h000, 8'd3);
    wr(4'd1, OP_STW, 10'h100, 8'd2);
    go(4'd1);
    for (int i = 0; i < 3; i++) cyc("t2.e0", 1'b1, 12'h400, 1'b0, 4'd0);
    cyc("t2.gap", 1'b0, 12'h400, 1'b0, 4'd0);
    for (int i = 0; i < 2; i++) cyc("t2.e1", 1'b1, 12'h900, 1'b0, 4'd1);
    cyc("t2.fin", 1'b0, 12'h900, 1'b1, 4'd1);
    chk("t2.busy_after", 32'(busy_out), 0);

    // Two-cycle stall after 2 beats: resume re-based to 0x022.
    wr(4'd0, OP_LDW, 10'h020, 8'd5);
    go(4'd0);
    cyc("t3.b1", 1'b1, 12'h420, 1'b0, 4'd0);
    stall_in = 1'b1;
    cyc("t3.b2", 1'b1, 12'h420, 1'b0, 4'd0);
    cyc("t3.s1", 1'b0, 12'h420, 1'b0, 4'd0);
    stall_in = 1'b0;
    cyc("t3.s2", 1'b0, 12'h420, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) cyc("t3.resume", 1'b1, 12'h422, 1'b0, 4'd0);
    cyc("t3.fin", 1'b0, 12'h422, 1'b1, 4'd0);

    // Address wrap on re-base: 0x3FE + 2 -> 0x000.
    wr(4'd0, OP_STW, 10'h3FE, 8'd4);
    go(4'd0);
    cyc("t4.b1", 1'b1, 12'hBFE, 1'b0, 4'd0);
    stall_in = 1'b1;
    cyc("t4.b2", 1'b1, 12'hBFE, 1'b0, 4'd0);
    stall_in = 1'b0;
    cyc("t4.s1", 1'b0, 12'hBFE, 1'b0, 4'd0);
    for (int i = 0; i < 2; i++) cyc("t4.resume", 1'b1, 12'h800, 1'b0, 4'd0);
    cyc("t4.fin", 1'b0, 12'h800, 1'b1, 4'd0);

    // Zero-length middle entry consumes one extra gap cycle.
    wr(4'd0, OP_LDW, 10'h040, 8'd1);
    wr(4'd1, OP_STW, 10'h050, 8'd0);
    wr(4'd2, OP_LDW, 10'h060, 8'd2);
    go(4'd2);
    cyc("t5.e0", 1'b1, 12'h440, 1'b0, 4'd0);
    cyc("t5.gap0", 1'b0, 12'h440, 1'b0, 4'd0);
    cyc("t5.skip1", 1'b0, 12'h440, 1'b0, 4'd1);
    for (int i = 0; i < 2; i++) cyc("t5.e2", 1'b1, 12'h460, 1'b0, 4'd2);
    cyc("t5.fin", 1'b0, 12'h460, 1'b1, 4'd2);

    // Zero-length entry that is also last: one gap cycle, then Finish.
    wr(4'd0, OP_LDW, 10'h070, 8'd0);
    go(4'd0);
    chk("t5s.busy", 32'(busy_out), 1);
    cyc("t5s.gap", 1'b0, 12'h460, 1'b0, 4'd0);
    cyc("t5s.fin", 1'b0, 12'h460, 1'b1, 4'd0);
    chk("t5s.busy_after", 32'(busy_out), 0);

    // Abort during beat 2 of 6.
    wr(4'd0, OP_LDW, 10'h080, 8'd6);
    go(4'd0);
    cyc("t6.b1", 1'b1, 12'h480, 1'b0, 4'd0);
    abort_in = 1'b1;
    cyc("t6.b2", 1'b1, 12'h480, 1'b0, 4'd0);
    abort_in = 1'b0;
    cyc("t6.fin", 1'b0, 12'h480, 1'b1, 4'd0);
    chk("t6.busy_after", 32'(busy_out), 0);
    chk("t6.en_after", 32'(LSU_En_out), 0);

    // Reset in the middle of the second entry.
    wr(4'd0, OP_STW, 10'h0C0, 8'd1);
    wr(4'd1, OP_LDW, 10'h0D0, 8'd3);
    go(4'd1);
    cyc("t7.e0", 1'b1, 12'h8C0, 1'b0, 4'd0);
    cyc("t7.gap", 1'b0, 12'h8C0, 1'b0, 4'd0);
    chk("t7.e1.en", 32'(LSU_En_out), 1);
    chk("t7.e1.ctx", 32'(ctx_idx_out), 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_zero("t7.rst");

    // Write and start while busy are both dropped.
    go(4'd1);
    cfg_we_in   = 1'b1;
    cfg_idx_in  = 4'd1;
    cfg_op_in   = OP_STW;
    cfg_base_in = 10'h3AA;
    cfg_len_in  = 8'd1;
    cyc("t8.e0", 1'b1, 12'h8C0, 1'b0, 4'd0);
    cfg_we_in   = 1'b0;
    start_in    = 1'b1;
    last_idx_in = 4'd0;
    cyc("t8.gap", 1'b0, 12'h8C0, 1'b0, 4'd0);
    start_in    = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t8.e1", 1'b1, 12'h4D0, 1'b0, 4'd1);
    cyc("t8.fin", 1'b0, 12'h4D0, 1'b1, 4'd1);
    chk("t8.busy_after", 32'(busy_out), 0);
    go(4'd1);
    cyc("t8r.e0", 1'b1, 12'h8C0, 1'b0, 4'd0);
    cyc("t8r.gap", 1'b0, 12'h8C0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) cyc("t8r.e1", 1'b1, 12'h4D0, 1'b0, 4'd1);
    cyc("t8r.fin", 1'b0, 12'h4D0, 1'b1, 4'd1);

    // Start coinciding with a table write is ignored.
    cfg_we_in   = 1'b1;
    cfg_idx_in  = 4'd7;
    cfg_op_in   = OP_LDW;
    cfg_base_in = 10'h000;
    cfg_len_in  = 8'd1;
    start_in    = 1'b1;
    last_idx_in = 4'd0;
    tick();
    cfg_we_in   = 1'b0;
    start_in    = 1'b0;
    chk("t9.busy", 32'(busy_out), 0);
    chk("t9.en", 32'(LSU_En_out), 0);
    tick();
    chk("t9.busy2", 32'(busy_out), 0);
    chk("t9.en2", 32'(LSU_En_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
